// File: rtl/mux_sched_pkg.sv
// Shared types and constants for the round-robin mux scheduler.
//   N_IN    : number of requesters / mux data inputs
//   SEL_W   : width of the mux select (log2 of N_IN)
//   sel_t   : mux select / requester index
//   state_t : scheduler FSM state
package mux_sched_pkg;

  localparam int N_IN  = 8;
  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

endpackage

// File: rtl/mux_rr_scheduler_rr_pick.sv
// Combinational round-robin pick: returns the first set bit of req,
// scanning from index ptr upward with wrap from N_IN-1 back to 0.
//   req   [N_IN-1:0] : request vector
//   ptr   sel_t      : highest-priority index for this pick
//   idx   sel_t      : winning index (0 when nothing found)
//   found 1          : at least one request is set
module rr_pick
  import mux_sched_pkg::*;
(
  input  logic [N_IN-1:0] req,
  input  sel_t            ptr,
  output sel_t            idx,
  output logic            found
);

  logic [2*N_IN-1:0] w_dbl;
  logic [N_IN-1:0]   w_rot;
  sel_t              w_off;

  // Rotate so that req[ptr] lands at bit 0; the doubled vector makes the
  // wrapped bits fall in naturally when shifting right.
  assign w_dbl = {req, req} >> ptr;
  assign w_rot = w_dbl[N_IN-1:0];

  // Priority-encode the lowest set bit of the rotated vector. Scanning from
  // the top down lets the last match (the lowest index) win.
  always_comb begin
    // NOTE: w_off gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_off = '0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = sel_t'(i);
    end
  end

  // Un-rotate: the offset is relative to ptr; 3-bit addition wraps mod 8.
  assign idx   = ptr + w_off;
  assign found = |req;

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler sharing an 8:1 single-bit mux among 8 requesters.
// Each grant lasts until the requester drops its request or BURST_LEN
// beats (valid && out_ready) have been accepted; release regrants on the
// same edge when another request is pending, with the releasing requester
// at lowest priority.
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   req       : per-requester request level
//   out_ready : downstream accepts the mux output this cycle
//   sel       : mux select (index of the granted requester)
//   grant     : one-hot grant, zero when idle
//   valid     : a grant is active, mux output is valid
//   beat_cnt  : beats accepted in the current grant
module mux_rr_scheduler
  import mux_sched_pkg::*;
#(
  parameter int BURST_LEN = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] req,
  input  logic            out_ready,
  output sel_t            sel,
  output logic [N_IN-1:0] grant,
  output logic            valid,
  output logic [3:0]      beat_cnt
);

  state_t          r_state, w_state_n;
  sel_t            r_ptr,   w_ptr_n;
  sel_t            r_sel,   w_sel_n;
  logic [N_IN-1:0] r_grant, w_grant_n;
  logic            r_valid, w_valid_n;
  logic [3:0]      r_beat,  w_beat_n;

  sel_t            w_pick_ptr;
  sel_t            w_idx;
  logic            w_found;
  logic            w_accept;
  logic            w_last;
  logic            w_release;

  // While granted, the only pick that matters is the one taken on release,
  // which starts just after the current owner.
  assign w_pick_ptr = (r_state == S_GRANT) ? r_sel + sel_t'(1) : r_ptr;

  rr_pick u_pick (
    .req   (req),
    .ptr   (w_pick_ptr),
    .idx   (w_idx),
    .found (w_found)
  );

  assign w_accept  = r_valid && out_ready;
  assign w_last    = w_accept && (r_beat == 4'(BURST_LEN - 1));
  // Drop and last beat in the same cycle collapse into one release.
  assign w_release = (r_state == S_GRANT) && (!req[r_sel] || w_last);

  always_comb begin
    w_state_n = r_state;
    w_ptr_n   = r_ptr;
    w_sel_n   = r_sel;
    w_grant_n = r_grant;
    w_valid_n = r_valid;
    w_beat_n  = r_beat;
    case (r_state)
      S_IDLE: begin
        w_beat_n = '0;
        if (w_found) begin
          w_state_n = S_GRANT;
          w_sel_n   = w_idx;
          w_grant_n = N_IN'(1) << w_idx;
          w_valid_n = 1'b1;
        end
      end
      S_GRANT: begin
        if (w_release) begin
          w_ptr_n  = r_sel + sel_t'(1);
          w_beat_n = '0;
          if (w_found) begin
            w_sel_n   = w_idx;
            w_grant_n = N_IN'(1) << w_idx;
          end else begin
            // sel keeps its last value while idle.
            w_state_n = S_IDLE;
            w_grant_n = '0;
            w_valid_n = 1'b0;
          end
        end else if (w_accept) begin
          w_beat_n = r_beat + 4'd1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_grant <= '0;
      r_valid <= 1'b0;
      r_beat  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      r_state <= w_state_n;
      r_ptr   <= w_ptr_n;
      r_sel   <= w_sel_n;
      r_grant <= w_grant_n;
      r_valid <= w_valid_n;
      r_beat  <= w_beat_n;
    end
  end

  assign sel      = r_sel;
  assign grant    = r_grant;
  assign valid    = r_valid;
  assign beat_cnt = r_beat;

endmodule

// File: doc/mux_rr_scheduler.md
Name: mux_rr_scheduler

Overview:
- Round-robin scheduler that shares the 8:1 single-bit multiplexer (multiplexor3: in[7:0], sel[2:0], out) among 8 requesters.
- Drives the mux `sel` and reports a one-hot `grant` to the requesters.
- Each granted requester holds the mux for a bounded burst of accepted beats, handshaken with the downstream consumer of `out`.
- Sits between the requester bank and the mux select input.

Parameters:
- N_IN, 8, number of requesters / mux inputs (fixed at 8 in this revision).
- SEL_W, 3, select width; equals log2(N_IN).
- BURST_LEN, 4, maximum accepted beats per grant; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  8  per-requester request level; held while the requester wants the mux.
- out_ready  in  1  downstream accepts the current mux output this cycle.
- sel  out  3  mux select; index of the granted requester.
- grant  out  8  one-hot grant; all zero when idle.
- valid  out  1  mux output is valid (a grant is active).
- beat_cnt  out  4  accepted beats in the current grant.

Behaviour:
- Reset (async, any time, including mid-burst):
  - sel=0, grant=0, valid=0, beat_cnt=0.
  - Round-robin pointer ptr=0; state=S_IDLE.
  - First grant after reset release is evaluated on the first clk edge with rst low.
- A beat is accepted when valid && out_ready are both high on a clk edge.
- The pick function is combinational. It returns the first set bit of req, scanning ptr, ptr+1, ..., ptr+7 mod 8, plus a found flag.
- Wrap-around: index 7 is followed by 0. ptr is updated as (idx+1) mod 8, 3-bit natural wrap.
- S_IDLE:
  - valid=0, grant=0; sel holds its last value; beat_cnt=0.
  - If pick finds a requester idx: on the next edge sel=idx, grant=1<<idx, valid=1, beat_cnt=0, state=S_GRANT. Latency from req rising to grant is 1 cycle.
- S_GRANT:
  - valid=1, grant one-hot at sel.
  - On an accepted beat, beat_cnt increments.
  - Release condition: req[sel]==0 on the edge, OR an accepted beat with beat_cnt==BURST_LEN-1.
  - If both release causes occur in the same cycle, the block releases exactly once. The beat is counted as delivered; no double advance.
  - On release: ptr_next=(sel+1) mod 8, and pick is re-evaluated with ptr_next against the current req.
    - If found: regrant on the same edge with no idle bubble. sel=new idx, beat_cnt=0. The releasing requester is eligible again but has the lowest priority.
    - If not found: enter S_IDLE, valid=0, grant=0.
  - out_ready low stalls: grant, sel and beat_cnt hold. Only req[sel] dropping can release during a stall.
- Requests arriving or dropping for non-granted indices have no effect until the next pick.
- grant and sel never change without a release. grant is never multi-hot.
- All outputs are registered; no combinational path from req or out_ready to any output.

Decomposition:
- Package mux_sched_pkg:
  - Constants N_IN=8, SEL_W=3.
  - typedef sel_t = logic [SEL_W-1:0].
  - typedef enum state_t {S_IDLE, S_GRANT}.
- Sub-module rr_pick (combinational): inputs req[7:0] and ptr; outputs idx (sel_t) and found.
  - Implemented as a rotate, priority-encode, un-rotate.
  - Unit-tested standalone.
- Top level holds the FSM, ptr, beat counter and output registers.

Test Plan:
1. Reset: assert rst mid-cycle with req=8'hFF -> immediately sel=0, grant=0, valid=0, beat_cnt=0. Release rst -> next edge grant=8'h01, sel=0.
2. Single requester: req=8'h08, out_ready=1 -> 1 cycle later grant=8'h08, sel=3. beat_cnt runs 0,1,2,3. Release after 4 beats and regrant 3 back-to-back with beat_cnt=0 and valid staying 1.
3. All requesting: req=8'hFF, out_ready=1 -> sel sequence 0,1,...,7,0, each held exactly 4 cycles; grant is always one-hot.
4. Stall: grant on 2, out_ready=0 for 5 cycles -> grant=8'h04, beat_cnt frozen. out_ready=1 -> burst completes after 4 accepted beats total.
5. Early drop: req[5] granted, drops after 2 beats while req[1] is set -> next edge sel=1, beat_cnt=0. Same-cycle drop plus last beat -> a single release, ptr=6.
6. Wrap and fairness: after grant of 7 with req=8'b0100_0001 -> grant 0 first, then 6. With req=0 after release -> valid=0, grant=0, sel holds.
